// File: rtl/lab4d_pkg.sv
// Shared types and defaults for the LAB4D readout scheduler.
package lab4d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } sched_state_e;

  localparam int unsigned ADDR_BITS_DEF     = 5;
  localparam int unsigned PRESCALE_BITS_DEF = 4;
  localparam int unsigned TIMEOUT_DEF       = 50000;
  localparam int unsigned TIMER_BITS        = 16;
  localparam int unsigned ENTRY_BITS_DEF    = ADDR_BITS_DEF + PRESCALE_BITS_DEF;

  function automatic int unsigned entry_bits(input int unsigned addr_bits,
                                             input int unsigned prescale_bits);
    return addr_bits + prescale_bits;
  endfunction

endpackage

// File: rtl/lab4d_sched_fifo.sv
// Synchronous request FIFO with flush; occupancy kept in a counter so
// pointers can wrap naturally at a power-of-2 depth.
module lab4d_sched_fifo
  import lab4d_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_BITS_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only entries below count_q are ever read out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lab4d_readout_sched.sv
// Queues LAB4 readout requests and issues them to the serial receiver one at a time.
// state      | meaning
// IDLE       | waiting for enable and a queued request
// ISSUE      | readout_o pulse, timeout counter cleared
// WAIT       | receiver busy; leave on complete_i or counter at TIMEOUT-1
// RELEASE    | report the released buffer with done_o next cycle
module lab4d_readout_sched
  import lab4d_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ADDR_BITS     = ADDR_BITS_DEF,
  parameter int unsigned PRESCALE_BITS = PRESCALE_BITS_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  input  logic                          clr_i,
  input  logic                          trig_i,
  input  logic [ADDR_BITS-1:0]          trig_addr_i,
  input  logic [PRESCALE_BITS-1:0]      trig_prescale_i,
  output logic                          readout_o,
  output logic [ADDR_BITS-1:0]          readout_address_o,
  output logic [PRESCALE_BITS-1:0]      prescale_o,
  input  logic                          complete_i,
  output logic                          done_o,
  output logic [ADDR_BITS-1:0]          done_addr_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o,
  output logic                          overflow_o,
  output logic                          timeout_o
);

  localparam int unsigned ENTRY_BITS = entry_bits(ADDR_BITS, PRESCALE_BITS);
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT - 1);

  sched_state_e             state_q;
  logic [TIMER_BITS-1:0]    timer_q;
  logic                     readout_q;
  logic [ADDR_BITS-1:0]     addr_q;
  logic [PRESCALE_BITS-1:0] presc_q;
  logic                     done_q;
  logic [ADDR_BITS-1:0]     done_addr_q;
  logic                     busy_q;
  logic                     overflow_q;
  logic                     overflow_d;
  logic                     timeout_q;
  logic                     timeout_d;

  logic [ENTRY_BITS-1:0]    head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     ovf_set;
  logic                     to_set;

  // Fullness is judged before any same-cycle pop, so a trig into a full queue is lost.
  assign push    = trig_i & ~fifo_full & ~flush_i;
  assign ovf_set = trig_i & fifo_full & ~flush_i;
  assign pop     = (state_q == ST_IDLE) & enable_i & ~fifo_empty & ~flush_i;
  assign to_set  = (state_q == ST_WAIT) & ~complete_i & (timer_q == TIMER_LAST);

  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (clr_i) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (ovf_set) overflow_d = 1'b1;
    if (to_set)  timeout_d  = 1'b1;
  end

  lab4d_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i ({trig_addr_i, trig_prescale_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      readout_q   <= 1'b0;
      addr_q      <= '0;
      presc_q     <= '0;
      done_q      <= 1'b0;
      done_addr_q <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      readout_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= (state_q != ST_IDLE);
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            addr_q    <= head[PRESCALE_BITS +: ADDR_BITS];
            presc_q   <= head[PRESCALE_BITS-1:0];
            readout_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          timer_q <= timer_q + TIMER_BITS'(1);
          if (complete_i || (timer_q == TIMER_LAST)) state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          done_q      <= 1'b1;
          done_addr_q <= addr_q;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign readout_o         = readout_q;
  assign readout_address_o = addr_q;
  assign prescale_o        = presc_q;
  assign done_o            = done_q;
  assign done_addr_o       = done_addr_q;
  assign busy_o            = busy_q;
  assign overflow_o        = overflow_q;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_lab4d_readout_sched.sv
// Directed bench for lab4d_readout_sched with hand-computed cycle expectations.
module tb_lab4d_readout_sched;

  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned ADDR_BITS     = 5;
  localparam int unsigned PRESCALE_BITS = 4;
  localparam int unsigned TIMEOUT       = 100;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic                     enable_i = 1'b1;
  logic                     flush_i = 1'b0;
  logic                     clr_i = 1'b0;
  logic                     trig_i = 1'b0;
  logic [ADDR_BITS-1:0]     trig_addr_i = '0;
  logic [PRESCALE_BITS-1:0] trig_prescale_i = '0;
  logic                     readout_o;
  logic [ADDR_BITS-1:0]     readout_address_o;
  logic [PRESCALE_BITS-1:0] prescale_o;
  logic                     complete_i = 1'b0;
  logic                     done_o;
  logic [ADDR_BITS-1:0]     done_addr_o;
  logic                     busy_o;
  logic [2:0]               pending_o;
  logic                     overflow_o;
  logic                     timeout_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  lab4d_readout_sched #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .ADDR_BITS     (ADDR_BITS),
    .PRESCALE_BITS (PRESCALE_BITS),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .enable_i          (enable_i),
    .flush_i           (flush_i),
    .clr_i             (clr_i),
    .trig_i            (trig_i),
    .trig_addr_i       (trig_addr_i),
    .trig_prescale_i   (trig_prescale_i),
    .readout_o         (readout_o),
    .readout_address_o (readout_address_o),
    .prescale_o        (prescale_o),
    .complete_i        (complete_i),
    .done_o            (done_o),
    .done_addr_o       (done_addr_o),
    .busy_o            (busy_o),
    .pending_o         (pending_o),
    .overflow_o        (overflow_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_readout(input int limit);
    int n;
    n = 0;
    while (!readout_o && n < limit) begin
      step();
      n++;
    end
    chk("readout_seen", 32'(readout_o), 1);
  endtask

  // Called in the ISSUE cycle: completes in the first WAIT cycle, done two cycles later.
  task automatic finish_readout(input logic [ADDR_BITS-1:0] addr);
    step();
    complete_i = 1'b1;
    step();
    complete_i = 1'b0;
    chk("done_early", 32'(done_o), 0);
    step();
    chk("done_pulse", 32'(done_o), 1);
    chk("done_addr", 32'(done_addr_o), 32'(addr));
  endtask

  initial begin
    step(2);
    chk("rst_readout", 32'(readout_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_pending", 32'(pending_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_addr", 32'(readout_address_o), 0);
    rst_i = 1'b1;
    step(2);

    // Single request: trig in cycle N, readout N+2, complete N+30, done N+32, busy low N+33.
    trig_i = 1'b1; trig_addr_i = 5'd7; trig_prescale_i = 4'd2;
    step();
    trig_i = 1'b0;
    chk("t1_pending", 32'(pending_o), 1);
    chk("t1_no_readout_yet", 32'(readout_o), 0);
    step();
    chk("t1_readout", 32'(readout_o), 1);
    chk("t1_addr", 32'(readout_address_o), 7);
    chk("t1_presc", 32'(prescale_o), 2);
    step(28);
    complete_i = 1'b1;
    chk("t1_busy_wait", 32'(busy_o), 1);
    step();
    complete_i = 1'b0;
    chk("t1_done_n31", 32'(done_o), 0);
    step();
    chk("t1_done", 32'(done_o), 1);
    chk("t1_done_addr", 32'(done_addr_o), 7);
    chk("t1_busy_rel", 32'(busy_o), 1);
    step();
    chk("t1_busy_low", 32'(busy_o), 0);
    chk("t1_done_gone", 32'(done_o), 0);
    chk("t1_addr_hold", 32'(readout_address_o), 7);
    step(2);

    // Queue fill: addr 1 issues, 2..5 queue, 6 dropped with overflow.
    for (int i = 1; i <= 6; i++) begin
      trig_i = 1'b1; trig_addr_i = ADDR_BITS'(i); trig_prescale_i = 4'd1;
      if (i == 6) begin
        chk("t2_full_pending", 32'(pending_o), 4);
        chk("t2_ovf_before", 32'(overflow_o), 0);
      end
      step();
    end
    trig_i = 1'b0;
    chk("t2_pending", 32'(pending_o), 4);
    chk("t2_overflow", 32'(overflow_o), 1);
    chk("t2_inflight", 32'(readout_address_o), 1);
    complete_i = 1'b1;
    step();
    complete_i = 1'b0;
    step();
    chk("t2_done1", 32'(done_o), 1);
    chk("t2_done_addr1", 32'(done_addr_o), 1);
    for (int k = 2; k <= 5; k++) begin
      wait_readout(8);
      chk("t2_issue_addr", 32'(readout_address_o), 32'(k));
      chk("t2_pending_left", 32'(pending_o), 32'(5 - k));
      finish_readout(ADDR_BITS'(k));
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t2_clr_ovf", 32'(overflow_o), 0);
    step(2);

    // Timeout: WAIT entered at R+1, timeout_o rises at R+101, done at R+102.
    trig_i = 1'b1; trig_addr_i = 5'd9; trig_prescale_i = 4'd3;
    step();
    trig_i = 1'b0;
    wait_readout(4);
    step(100);
    chk("t3_to_pre", 32'(timeout_o), 0);
    chk("t3_done_pre", 32'(done_o), 0);
    chk("t3_busy", 32'(busy_o), 1);
    step();
    chk("t3_timeout", 32'(timeout_o), 1);
    chk("t3_done_rel", 32'(done_o), 0);
    step();
    chk("t3_done", 32'(done_o), 1);
    chk("t3_done_addr", 32'(done_addr_o), 9);
    step();
    complete_i = 1'b1;
    step();
    complete_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_stray_done", 32'(done_o), 0);
      chk("t3_stray_busy", 32'(busy_o), 0);
      step();
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t3_clr_to", 32'(timeout_o), 0);

    // Enable/flush: entries retained while disabled, flush drops them and a same-cycle trig.
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      trig_i = 1'b1; trig_addr_i = ADDR_BITS'(10 + i); trig_prescale_i = 4'd0;
      step();
    end
    trig_i = 1'b0;
    step();
    chk("t4_pending3", 32'(pending_o), 3);
    chk("t4_no_readout", 32'(readout_o), 0);
    chk("t4_idle", 32'(busy_o), 0);
    flush_i = 1'b1; trig_i = 1'b1; trig_addr_i = 5'd14;
    step();
    flush_i = 1'b0; trig_i = 1'b0;
    chk("t4_flushed", 32'(pending_o), 0);
    chk("t4_flush_no_ovf", 32'(overflow_o), 0);
    enable_i = 1'b1;
    trig_i = 1'b1; trig_addr_i = 5'd13; trig_prescale_i = 4'd5;
    step();
    trig_i = 1'b0;
    wait_readout(4);
    chk("t4_addr", 32'(readout_address_o), 13);
    chk("t4_presc", 32'(prescale_o), 5);
    finish_readout(5'd13);
    step(2);

    // complete_i on the timeout cycle counts as completion.
    trig_i = 1'b1; trig_addr_i = 5'd17; trig_prescale_i = 4'd6;
    step();
    trig_i = 1'b0;
    wait_readout(4);
    step(100);
    complete_i = 1'b1;
    step();
    complete_i = 1'b0;
    chk("t5_to_rel", 32'(timeout_o), 0);
    step();
    chk("t5_done", 32'(done_o), 1);
    chk("t5_done_addr", 32'(done_addr_o), 17);
    chk("t5_to_stays", 32'(timeout_o), 0);
    step(2);

    // Trig into a full queue on the pop cycle: dropped, overflow set.
    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      trig_i = 1'b1; trig_addr_i = ADDR_BITS'(20 + i); trig_prescale_i = 4'd4;
      step();
    end
    enable_i = 1'b1;
    trig_i = 1'b1; trig_addr_i = 5'd24;
    chk("t6_pending_full", 32'(pending_o), 4);
    step();
    trig_i = 1'b0;
    chk("t6_overflow", 32'(overflow_o), 1);
    chk("t6_pending_pop", 32'(pending_o), 3);
    chk("t6_readout", 32'(readout_o), 1);
    chk("t6_addr", 32'(readout_address_o), 20);
    step(3);

    // Asynchronous reset in WAIT.
    chk("t7_busy_pre", 32'(busy_o), 1);
    rst_i = 1'b0;
    #1;
    chk("t7_readout", 32'(readout_o), 0);
    chk("t7_addr", 32'(readout_address_o), 0);
    chk("t7_presc", 32'(prescale_o), 0);
    chk("t7_busy", 32'(busy_o), 0);
    chk("t7_pending", 32'(pending_o), 0);
    chk("t7_done", 32'(done_o), 0);
    chk("t7_done_addr", 32'(done_addr_o), 0);
    chk("t7_overflow", 32'(overflow_o), 0);
    chk("t7_timeout", 32'(timeout_o), 0);
    step();
    rst_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t7_no_done", 32'(done_o), 0);
      chk("t7_no_readout", 32'(readout_o), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
